// File: rtl/nios_fprint_dma_pkg.sv
// Shared definitions for the scratchpad DMA: CSR indices, CTRL/STATUS bit
// positions, FSM state encoding and a small address helper.
package nios_fprint_dma_pkg;

    // CSR word indices
    localparam logic [2:0] CSR_MADDR    = 3'd0;
    localparam logic [2:0] CSR_SPOFF    = 3'd1;
    localparam logic [2:0] CSR_LENGTH   = 3'd2;
    localparam logic [2:0] CSR_CTRL     = 3'd3;
    localparam logic [2:0] CSR_STATUS   = 3'd4;
    localparam logic [2:0] CSR_CHECKSUM = 3'd5;

    // CTRL bit positions
    localparam int CTRL_GO     = 0;
    localparam int CTRL_DIR    = 1;
    localparam int CTRL_IRQ_EN = 2;

    // STATUS bit positions
    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;

    // Byte distance between consecutive words on the master side
    localparam logic [31:0] WORD_STRIDE = 32'd4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LD_RD  = 3'd1,
        S_LD_WR  = 3'd2,
        S_WB_RD  = 3'd3,
        S_WB_CAP = 3'd4,
        S_WB_WR  = 3'd5
    } dma_state_e;

    // Force a byte address onto a word boundary
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/nios_fprint_dma_csr.sv
// CSR slave of the scratchpad DMA: configuration registers, sticky
// DONE/ERR with write-1-to-clear (a same-cycle set wins), registered read data.
module nios_fprint_dma_csr
    import nios_fprint_dma_pkg::*;
#(
    parameter int SP_AW = 12,
    parameter int LEN_W = 13
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       csr_address,
    input  logic             csr_chipselect,
    input  logic             csr_read,
    input  logic             csr_write,
    input  logic [31:0]      csr_writedata,
    output logic [31:0]      csr_readdata,
    input  logic             busy,
    input  logic             done_set,
    input  logic             err_set,
    input  logic [31:0]      checksum,
    output logic [31:0]      maddr,
    output logic [SP_AW-1:0] spoff,
    output logic [LEN_W-1:0] length,
    output logic             go,
    output logic             go_dir,
    output logic             irq
);

    logic             wr_s;
    logic             rd_s;
    logic [31:0]      rd_mux_s;
    logic [31:0]      maddr_r;
    logic [SP_AW-1:0] spoff_r;
    logic [LEN_W-1:0] length_r;
    logic             dir_r;
    logic             irq_en_r;
    logic             done_r;
    logic             err_r;

    assign wr_s   = csr_chipselect & csr_write;
    assign rd_s   = csr_chipselect & csr_read;
    assign maddr  = maddr_r;
    assign spoff  = spoff_r;
    assign length = length_r;
    // GO is a pulse taken straight from the write; the FSM needs DIR in the same cycle
    assign go     = wr_s && (csr_address == CSR_CTRL) && csr_writedata[CTRL_GO];
    assign go_dir = csr_writedata[CTRL_DIR];
    assign irq    = done_r & irq_en_r;

    // Configuration registers; writes while busy never touch the engine's working copies
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            maddr_r  <= 32'd0;
            spoff_r  <= {SP_AW{1'b0}};
            length_r <= {LEN_W{1'b0}};
            dir_r    <= 1'b0;
            irq_en_r <= 1'b0;
        end else if (wr_s) begin
            case (csr_address)
                CSR_MADDR:  maddr_r  <= word_align(csr_writedata);
                CSR_SPOFF:  spoff_r  <= csr_writedata[SP_AW-1:0];
                CSR_LENGTH: length_r <= csr_writedata[LEN_W-1:0];
                CSR_CTRL: begin
                    dir_r    <= csr_writedata[CTRL_DIR];
                    irq_en_r <= csr_writedata[CTRL_IRQ_EN];
                end
                default:    maddr_r  <= maddr_r;
            endcase
        end
    end

    // Sticky completion flags: engine set has priority over a host clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            if (done_set) begin
                done_r <= 1'b1;
            end else if (wr_s && (csr_address == CSR_STATUS) && csr_writedata[STAT_DONE]) begin
                done_r <= 1'b0;
            end
            if (err_set) begin
                err_r <= 1'b1;
            end else if (wr_s && (csr_address == CSR_STATUS) && csr_writedata[STAT_ERR]) begin
                err_r <= 1'b0;
            end
        end
    end

    // Read-back multiplexer; unmapped indices read zero
    always_comb begin
        rd_mux_s = 32'd0;
        case (csr_address)
            CSR_MADDR:    rd_mux_s = maddr_r;
            CSR_SPOFF:    rd_mux_s = {{(32-SP_AW){1'b0}}, spoff_r};
            CSR_LENGTH:   rd_mux_s = {{(32-LEN_W){1'b0}}, length_r};
            CSR_CTRL:     rd_mux_s = {29'd0, irq_en_r, dir_r, 1'b0};
            CSR_STATUS:   rd_mux_s = {29'd0, err_r, done_r, busy};
            CSR_CHECKSUM: rd_mux_s = checksum;
            default:      rd_mux_s = 32'd0;
        endcase
    end

    // Registered read data, updated only on a selected read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csr_readdata <= 32'd0;
        end else if (rd_s) begin
            csr_readdata <= rd_mux_s;
        end
    end

endmodule

// File: rtl/nios_fprint_scratchpad_dma.sv
// Single-channel word-copy engine between main memory and a scratchpad port.
// Optional feature macro: FPRINT_DMA_CHECKSUM_EN builds a running 32-bit sum
// of transferred words readable at CSR 5 (reads 0 when not built).
module nios_fprint_scratchpad_dma
    import nios_fprint_dma_pkg::*;
#(
    parameter int SP_AW = 12,
    parameter int LEN_W = 13
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       csr_address,
    input  logic             csr_chipselect,
    input  logic             csr_read,
    input  logic             csr_write,
    input  logic [31:0]      csr_writedata,
    output logic [31:0]      csr_readdata,
    output logic             irq,
    output logic [31:0]      m_address,
    output logic             m_read,
    output logic             m_write,
    output logic [31:0]      m_writedata,
    input  logic [31:0]      m_readdata,
    input  logic             m_waitrequest,
    output logic [SP_AW-1:0] sp_address,
    output logic             sp_chipselect,
    output logic             sp_write,
    output logic             sp_clken,
    output logic [3:0]       sp_byteenable,
    output logic [31:0]      sp_writedata,
    input  logic [31:0]      sp_readdata
);

    localparam logic [SP_AW-1:0] SP_ONE   = SP_AW'(1);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
    // 2^SP_AW expressed at LEN_W+1 bits for the range check
    localparam logic [LEN_W:0]   SP_LIMIT = {{(LEN_W-SP_AW){1'b0}}, 1'b1, {SP_AW{1'b0}}};

    dma_state_e       state_r;
    dma_state_e       state_s;
    logic [31:0]      cur_m_r;
    logic [SP_AW-1:0] cur_sp_r;
    logic [LEN_W-1:0] remain_r;
    logic [31:0]      data_r;

    logic [31:0]      maddr_s;
    logic [SP_AW-1:0] spoff_s;
    logic [LEN_W-1:0] length_s;
    logic             go_s;
    logic             go_dir_s;
    logic             go_accept_s;
    logic [LEN_W:0]   span_s;
    logic             len_zero_s;
    logic             overflow_s;
    logic             last_s;
    logic             busy_s;
    logic             done_set_s;
    logic             err_set_s;
    logic             advance_s;
    logic             cap_m_s;
    logic             cap_sp_s;
    logic [31:0]      checksum_s;

    nios_fprint_dma_csr #(
        .SP_AW (SP_AW),
        .LEN_W (LEN_W)
    ) u_csr (
        .clk            (clk),
        .reset          (reset),
        .csr_address    (csr_address),
        .csr_chipselect (csr_chipselect),
        .csr_read       (csr_read),
        .csr_write      (csr_write),
        .csr_writedata  (csr_writedata),
        .csr_readdata   (csr_readdata),
        .busy           (busy_s),
        .done_set       (done_set_s),
        .err_set        (err_set_s),
        .checksum       (checksum_s),
        .maddr          (maddr_s),
        .spoff          (spoff_s),
        .length         (length_s),
        .go             (go_s),
        .go_dir         (go_dir_s),
        .irq            (irq)
    );

    assign busy_s        = (state_r != S_IDLE);
    assign go_accept_s   = go_s && (state_r == S_IDLE);
    assign span_s        = (LEN_W+1)'(spoff_s) + (LEN_W+1)'(length_s);
    assign len_zero_s    = (length_s == {LEN_W{1'b0}});
    assign overflow_s    = (span_s > SP_LIMIT);
    assign last_s        = (remain_r == LEN_ONE);

    assign m_address     = word_align(cur_m_r);
    assign m_writedata   = data_r;
    assign sp_address    = cur_sp_r;
    assign sp_writedata  = data_r;
    assign sp_clken      = 1'b1;
    assign sp_byteenable = 4'hF;

    // FSM state register; async reset drops all strobes immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state, bus strobes and datapath control
    always_comb begin
        state_s       = state_r;
        m_read        = 1'b0;
        m_write       = 1'b0;
        sp_chipselect = 1'b0;
        sp_write      = 1'b0;
        done_set_s    = 1'b0;
        err_set_s     = 1'b0;
        advance_s     = 1'b0;
        cap_m_s       = 1'b0;
        cap_sp_s      = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (go_s) begin
                    if (len_zero_s) begin
                        done_set_s = 1'b1;
                    end else if (overflow_s) begin
                        err_set_s  = 1'b1;
                        done_set_s = 1'b1;
                    end else if (go_dir_s) begin
                        state_s = S_WB_RD;
                    end else begin
                        state_s = S_LD_RD;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_LD_RD: begin
                m_read = 1'b1;
                if (!m_waitrequest) begin
                    cap_m_s = 1'b1;
                    state_s = S_LD_WR;
                end else begin
                    state_s = S_LD_RD;
                end
            end
            S_LD_WR: begin
                sp_chipselect = 1'b1;
                sp_write      = 1'b1;
                advance_s     = 1'b1;
                if (last_s) begin
                    done_set_s = 1'b1;
                    state_s    = S_IDLE;
                end else begin
                    state_s = S_LD_RD;
                end
            end
            S_WB_RD: begin
                sp_chipselect = 1'b1;
                state_s       = S_WB_CAP;
            end
            S_WB_CAP: begin
                cap_sp_s = 1'b1;
                state_s  = S_WB_WR;
            end
            S_WB_WR: begin
                m_write = 1'b1;
                if (!m_waitrequest) begin
                    advance_s = 1'b1;
                    if (last_s) begin
                        done_set_s = 1'b1;
                        state_s    = S_IDLE;
                    end else begin
                        state_s = S_WB_RD;
                    end
                end else begin
                    state_s = S_WB_WR;
                end
            end
            default: state_s = S_IDLE;
        endcase
    end

    // Working copies and the one-word data holding register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_m_r  <= 32'd0;
            cur_sp_r <= {SP_AW{1'b0}};
            remain_r <= {LEN_W{1'b0}};
            data_r   <= 32'd0;
        end else begin
            if (go_accept_s) begin
                cur_m_r  <= maddr_s;
                cur_sp_r <= spoff_s;
                remain_r <= length_s;
            end else if (advance_s) begin
                cur_m_r  <= cur_m_r + WORD_STRIDE;
                cur_sp_r <= cur_sp_r + SP_ONE;
                remain_r <= remain_r - LEN_ONE;
            end
            if (cap_m_s) begin
                data_r <= m_readdata;
            end else if (cap_sp_s) begin
                data_r <= sp_readdata;
            end
        end
    end

`ifdef FPRINT_DMA_CHECKSUM_EN
    logic [31:0] sum_r;

    // Running sum of every captured word, restarted by each GO taken in IDLE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_r <= 32'd0;
        end else if (go_accept_s) begin
            sum_r <= 32'd0;
        end else if (cap_m_s) begin
            sum_r <= sum_r + m_readdata;
        end else if (cap_sp_s) begin
            sum_r <= sum_r + sp_readdata;
        end
    end

    assign checksum_s = sum_r;
`else
    assign checksum_s = 32'd0;
`endif

endmodule

// File: tb/tb_nios_fprint_scratchpad_dma.sv
// Self-checking bench for nios_fprint_scratchpad_dma: behavioural main-memory
// and scratchpad models, randomized transfers and wait states, and a
// reference computed from the transfer rules (data placement, cycle cost).
module tb_nios_fprint_scratchpad_dma;

    localparam int SP_AW    = 12;
    localparam int LEN_W    = 13;
    localparam int SP_DEPTH = 4096;

    localparam logic [2:0] A_MADDR  = 3'd0;
    localparam logic [2:0] A_SPOFF  = 3'd1;
    localparam logic [2:0] A_LENGTH = 3'd2;
    localparam logic [2:0] A_CTRL   = 3'd3;
    localparam logic [2:0] A_STATUS = 3'd4;
    localparam logic [2:0] A_CSUM   = 3'd5;

    logic             clk = 1'b0;
    logic             reset;
    logic [2:0]       csr_address;
    logic             csr_chipselect;
    logic             csr_read;
    logic             csr_write;
    logic [31:0]      csr_writedata;
    logic [31:0]      csr_readdata;
    logic             irq;
    logic [31:0]      m_address;
    logic             m_read;
    logic             m_write;
    logic [31:0]      m_writedata;
    logic [31:0]      m_readdata;
    logic             m_waitrequest;
    logic [SP_AW-1:0] sp_address;
    logic             sp_chipselect;
    logic             sp_write;
    logic             sp_clken;
    logic [3:0]       sp_byteenable;
    logic [31:0]      sp_writedata;
    logic [31:0]      sp_readdata;

    always #5 clk = ~clk;

    nios_fprint_scratchpad_dma #(.SP_AW(SP_AW), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset),
        .csr_address(csr_address), .csr_chipselect(csr_chipselect),
        .csr_read(csr_read), .csr_write(csr_write),
        .csr_writedata(csr_writedata), .csr_readdata(csr_readdata), .irq(irq),
        .m_address(m_address), .m_read(m_read), .m_write(m_write),
        .m_writedata(m_writedata), .m_readdata(m_readdata), .m_waitrequest(m_waitrequest),
        .sp_address(sp_address), .sp_chipselect(sp_chipselect), .sp_write(sp_write),
        .sp_clken(sp_clken), .sp_byteenable(sp_byteenable),
        .sp_writedata(sp_writedata), .sp_readdata(sp_readdata)
    );

    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- memory models ----------------
    logic [31:0] pre_base = 32'd0;
    logic [31:0] pre_tab [0:63];
    int          waits_tab [0:1023];
    int          acc_idx    = 0;
    int          stall_cnt  = 0;
    int          n_strobe   = 0;
    int          stall_viol = 0;
    int          wb_n       = 0;
    logic [31:0] wb_addr [0:1023];
    logic [31:0] wb_data [0:1023];
    logic [31:0] sp_mem  [0:SP_DEPTH-1];
    logic [31:0] sp_ref  [0:SP_DEPTH-1];
    logic        prev_stall_rd = 1'b0;
    logic        prev_stall_wr = 1'b0;
    logic [31:0] prev_addr     = 32'd0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] off;
        off = a - pre_base;
        if (off < 32'd256) return pre_tab[off[7:2]];
        return a ^ 32'hDEAD_BEEF;
    endfunction

    // Main-memory slave: read data and stall presented mid-cycle
    always @(negedge clk) begin
        m_readdata    = mem_word(m_address);
        m_waitrequest = (m_read || m_write) && (stall_cnt < waits_tab[acc_idx]);
    end

    // Bus bookkeeping plus the scratchpad RAM (one-cycle read latency)
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt     <= 0;
            prev_stall_rd <= 1'b0;
            prev_stall_wr <= 1'b0;
        end else begin
            if (m_read || m_write || sp_chipselect) n_strobe <= n_strobe + 1;
            if (prev_stall_rd && !(m_read && m_address == prev_addr)) stall_viol <= stall_viol + 1;
            if (prev_stall_wr && !(m_write && m_address == prev_addr)) stall_viol <= stall_viol + 1;
            prev_stall_rd <= m_read && m_waitrequest;
            prev_stall_wr <= m_write && m_waitrequest;
            prev_addr     <= m_address;
            if (m_read || m_write) begin
                if (m_waitrequest) begin
                    stall_cnt <= stall_cnt + 1;
                end else begin
                    stall_cnt <= 0;
                    acc_idx   <= (acc_idx + 1) % 1024;
                    if (m_write) begin
                        wb_addr[wb_n % 1024] <= m_address;
                        wb_data[wb_n % 1024] <= m_writedata;
                        wb_n <= wb_n + 1;
                    end
                end
            end
            if (sp_chipselect && sp_write) sp_mem[sp_address] <= sp_writedata;
            sp_readdata <= sp_mem[sp_address];
        end
    end

    // ---------------- CSR access ----------------
    task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
        csr_address = a; csr_writedata = d; csr_chipselect = 1'b1; csr_write = 1'b1;
        @(posedge clk); @(negedge clk);
        csr_chipselect = 1'b0; csr_write = 1'b0;
    endtask

    task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
        csr_address = a; csr_chipselect = 1'b1; csr_read = 1'b1;
        @(posedge clk); @(negedge clk);
        csr_chipselect = 1'b0; csr_read = 1'b0;
        d = csr_readdata;
    endtask

    // One complete transfer with reference checks. Load data comes from pre_tab.
    task automatic run_xfer(input string tag, input bit dir, input logic [31:0] maddr,
                            input int spoff, input int len, input int wmin, input int wmax,
                            input bit meddle);
        int          exp_cyc, cyc, wsum, strobe0, wb0, viol0, w;
        bit          bad;
        logic [31:0] rd, exp_sum;
        bad  = (len != 0) && (spoff + len > SP_DEPTH);
        wsum = 0;
        for (int i = 0; i < len; i++) begin
            w = int'($urandom_range(wmax, wmin));
            waits_tab[(acc_idx + i) % 1024] = w;
            wsum += w;
        end
        if (!dir) pre_base = maddr;
        csr_wr(A_MADDR, maddr);
        csr_wr(A_SPOFF, 32'(spoff));
        csr_wr(A_LENGTH, 32'(len));
        csr_wr(A_STATUS, 32'h6);
        strobe0 = n_strobe; wb0 = wb_n; viol0 = stall_viol;
        csr_wr(A_CTRL, {29'd0, 1'b1, dir, 1'b1});
        cyc = 1;
        if (meddle) begin
            csr_wr(A_CTRL, 32'h7);
            csr_wr(A_MADDR, maddr ^ 32'h0000_8000);
            cyc += 2;
        end
        exp_cyc = (len == 0 || bad) ? 1 : (dir ? 3 : 2) * len + wsum + 1;
        while (!irq && cyc < exp_cyc + 64) begin
            @(negedge clk);
            cyc++;
        end
        check_val({tag, " done_cycle"}, 32'(cyc), 32'(exp_cyc));
        csr_rd(A_STATUS, rd);
        check_val({tag, " status"}, rd, bad ? 32'h6 : 32'h2);
        check_val({tag, " strobe_cycles"}, 32'(n_strobe - strobe0),
                  (len == 0 || bad) ? 32'd0 : 32'(2 * len + wsum));
        check_val({tag, " stall_steady"}, 32'(stall_viol - viol0), 32'd0);
        check_val({tag, " mwrites"}, 32'(wb_n - wb0), (dir && !bad) ? 32'(len) : 32'd0);
        exp_sum = 32'd0;
        if (!bad) begin
            for (int i = 0; i < len; i++) begin
                if (!dir) begin
                    check_val({tag, " sp_data"}, sp_mem[spoff + i], pre_tab[i]);
                    sp_ref[spoff + i] = pre_tab[i];
                    exp_sum += pre_tab[i];
                end else begin
                    check_val({tag, " m_addr"}, wb_addr[(wb0 + i) % 1024], maddr + 32'(4 * i));
                    check_val({tag, " m_data"}, wb_data[(wb0 + i) % 1024], sp_ref[spoff + i]);
                    exp_sum += sp_ref[spoff + i];
                end
            end
        end
        csr_rd(A_CSUM, rd);
`ifdef FPRINT_DMA_CHECKSUM_EN
        check_val({tag, " checksum"}, rd, exp_sum);
`else
        check_val({tag, " checksum"}, rd, 32'd0);
`endif
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] rd;
        int          s0, len, spoff;
        bit          dir;
        logic [31:0] maddr;

        for (int i = 0; i < 1024; i++) waits_tab[i] = 0;
        reset = 1'b1;
        csr_address = 3'd0; csr_chipselect = 1'b0; csr_read = 1'b0; csr_write = 1'b0;
        csr_writedata = 32'd0;
        repeat (3) @(negedge clk);
        check_val("rst m_read", {31'd0, m_read}, 32'd0);
        check_val("rst sp_chipselect", {31'd0, sp_chipselect}, 32'd0);
        check_val("rst sp_clken", {31'd0, sp_clken}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check_val("rst sp_byteenable", {28'd0, sp_byteenable}, 32'hF);
        check_val("rst irq", {31'd0, irq}, 32'd0);
        check_val("rst m_address", m_address, 32'd0);
        check_val("rst csr_readdata", csr_readdata, 32'd0);
        csr_rd(A_STATUS, rd); check_val("rst status", rd, 32'd0);
        csr_rd(A_CTRL, rd);   check_val("rst ctrl", rd, 32'd0);
        csr_wr(A_MADDR, 32'h1234_5677);
        csr_rd(A_MADDR, rd);  check_val("maddr align", rd, 32'h1234_5674);
        csr_rd(3'd7, rd);     check_val("unmapped", rd, 32'd0);

        // Directed transfers
        for (int i = 0; i < 4; i++) pre_tab[i] = 32'hA0 + 32'(i);
        run_xfer("load0", 1'b0, 32'h1000, 10, 4, 0, 0, 1'b0);
        run_xfer("load3", 1'b0, 32'h1000, 10, 4, 3, 3, 1'b0);
        for (int i = 0; i < 64; i++) pre_tab[i] = $urandom;
        run_xfer("wbpre", 1'b0, 32'h5000, 4094, 2, 0, 0, 1'b0);
        run_xfer("wb", 1'b1, 32'h1000, 4094, 2, 0, 1, 1'b0);
        run_xfer("err", 1'b0, 32'h1000, 4095, 2, 0, 0, 1'b0);
        run_xfer("len0", 1'b1, 32'h1000, 7, 0, 0, 0, 1'b0);
        run_xfer("fit", 1'b0, 32'h3000, 4095, 1, 0, 2, 1'b0);

        // irq follows DONE; clearing DONE drops irq on the next cycle
        check_val("irq high", {31'd0, irq}, 32'd1);
        csr_wr(A_STATUS, 32'h2);
        check_val("irq w1c", {31'd0, irq}, 32'd0);

        // GO and MADDR written while busy must not disturb the running load
        for (int i = 0; i < 64; i++) pre_tab[i] = $urandom;
        run_xfer("busy", 1'b0, 32'h4000, 100, 8, 1, 2, 1'b1);

        // Randomized transfers: seed a region, then mix loads and writebacks
        for (int i = 0; i < 64; i++) pre_tab[i] = $urandom;
        run_xfer("seed", 1'b0, 32'h8000_0000, 256, 64, 0, 1, 1'b0);
        run_xfer("wrap", 1'b1, 32'hFFFF_FFF8, 260, 4, 0, 2, 1'b0);
        for (int k = 0; k < 8; k++) begin
            dir = 1'($urandom_range(1, 0));
            len = int'($urandom_range(16, 1));
            maddr = {$urandom_range(32'h3FFF_FFFF, 0), 2'b00};
            if (dir) begin
                spoff = 256 + int'($urandom_range(48, 0));
            end else begin
                spoff = int'($urandom_range(SP_DEPTH - 1, 0));
                for (int i = 0; i < 64; i++) pre_tab[i] = $urandom;
            end
            run_xfer(dir ? "rnd_wb" : "rnd_ld", dir, maddr, spoff, len, 0, 2, 1'b0);
        end

        // Reset while the engine is stalled in a read
        for (int i = 0; i < 4; i++) waits_tab[(acc_idx + i) % 1024] = 3;
        pre_base = 32'h1000;
        csr_wr(A_MADDR, 32'h1000);
        csr_wr(A_SPOFF, 32'd20);
        csr_wr(A_LENGTH, 32'd4);
        csr_wr(A_CTRL, 32'h5);
        check_val("mid m_read", {31'd0, m_read}, 32'd1);
        @(negedge clk);
        check_val("mid stall", {31'd0, m_waitrequest}, 32'd1);
        #2 reset = 1'b1;
        #1 check_val("async m_read", {31'd0, m_read}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        s0 = n_strobe;
        @(negedge clk);
        check_val("post irq", {31'd0, irq}, 32'd0);
        csr_rd(A_STATUS, rd); check_val("post status", rd, 32'd0);
        csr_rd(A_CTRL, rd);   check_val("post ctrl", rd, 32'd0);
        repeat (4) @(negedge clk);
        check_val("post strobes", 32'(n_strobe - s0), 32'd0);
        for (int i = 0; i < 64; i++) pre_tab[i] = $urandom;
        run_xfer("post_rst", 1'b0, 32'h2000, 30, 5, 0, 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/nios_fprint_scratchpad_dma.md
# nios_fprint_scratchpad_dma

Single-channel word-copy engine that sits directly upstream of a processor's scratchpad RAM. It moves blocks of 32-bit words between main memory and the scratchpad's second port. Load copies main memory to the scratchpad; writeback copies the scratchpad to main memory. The host programs it through a small CSR slave, and the engine signals completion by a sticky status bit and an optional interrupt.

## Interface
- `SP_AW`, 12: scratchpad word-address width (depth 2^SP_AW).
- `LEN_W`, 13: width of the LENGTH register; must satisfy LEN_W ≥ SP_AW+1.
- `clk` in 1: sole clock.
- `reset` in 1: asynchronous, active-high reset.
- `csr_address` in 3: CSR word index.
- `csr_chipselect`, `csr_read`, `csr_write` in 1 each: CSR access strobes.
- `csr_writedata` in 32: CSR write data.
- `csr_readdata` out 32: CSR read data, registered.
- `irq` out 1: completion interrupt.
- `m_address` out 32: master byte address, always word aligned.
- `m_read`, `m_write` out 1 each: master strobes.
- `m_writedata` out 32: master write data.
- `m_readdata` in 32: master read data.
- `m_waitrequest` in 1: master stall.
- `sp_address` out SP_AW: scratchpad word address.
- `sp_chipselect`, `sp_write`, `sp_clken` out 1 each: scratchpad controls.
- `sp_byteenable` out 4: constant 4'hF.
- `sp_writedata` out 32: scratchpad write data.
- `sp_readdata` in 32: scratchpad read data, valid one cycle after the address.

## Operation
- CSR map:
  - 0 MADDR (rw; bits [1:0] read as 0).
  - 1 SPOFF (rw, word offset).
  - 2 LENGTH (rw, words).
  - 3 CTRL: bit0 GO (write-only, self-clearing), bit1 DIR (0=load, 1=writeback), bit2 IRQ_EN.
  - 4 STATUS: bit0 BUSY (ro), bit1 DONE (W1C), bit2 ERR (W1C).
  - 5 CHECKSUM (see Configuration).
  - Unmapped indices read 0.
- FSM states: IDLE, LD_RD, LD_WR, WB_RD, WB_CAP, WB_WR.
- GO in IDLE:
  - Working copies are latched: cur_m=MADDR, cur_sp=SPOFF, remain=LENGTH.
  - If LENGTH=0: set DONE, stay IDLE.
  - If SPOFF+LENGTH > 2^SP_AW (computed at LEN_W+1 bits): set ERR and DONE, no bus activity.
  - Otherwise BUSY=1 and go to LD_RD (DIR=0) or WB_RD (DIR=1).
- Load path:
  - LD_RD: m_read=1, m_address=cur_m. Hold until m_waitrequest=0, then capture m_readdata and go to LD_WR.
  - LD_WR: sp_chipselect=sp_write=1, sp_address=cur_sp. Then cur_m+=4, cur_sp+=1, remain-=1. Go to LD_RD if remain≠0, else IDLE with DONE set.
- Writeback path:
  - WB_RD: sp_chipselect=1, sp_write=0, address cur_sp.
  - WB_CAP: capture sp_readdata.
  - WB_WR: m_write=1 and hold until m_waitrequest=0, then increment/decrement as in load. Go to WB_RD if remain≠0, else IDLE with DONE set.
- GO while BUSY is ignored. CSR writes to MADDR/SPOFF/LENGTH while BUSY update the registers only, never the working copies.
- A new GO does not clear DONE or ERR automatically.
- irq = DONE & IRQ_EN (combinational from registers).
- sp_clken = 1 always.
- m_address wraps modulo 2^32 with no error.

## Timing
- Reset values: all outputs 0 except sp_byteenable=4'hF and sp_clken=1. All registers 0, FSM in IDLE.
- Reset mid-transfer: strobes drop asynchronously. The partial transfer is abandoned with no DONE.
- csr_readdata is valid the cycle after csr_read & csr_chipselect.
- GO written at cycle N: first strobe (m_read or sp_chipselect) at cycle N+1.
- Per-word cost with zero wait states: load 2 cycles, writeback 3 cycles. Each wait-state cycle adds 1.
- DONE is set on the cycle after the last LD_WR/WB_WR completes; irq rises in the same cycle.
- Same-cycle W1C of DONE and the final word completing: set wins.

## Configuration
- `FPRINT_DMA_CHECKSUM_EN` defined:
  - A 32-bit running sum (mod 2^32) of every transferred word is maintained.
  - It is cleared on an accepted GO and readable at CSR 5.
  - The value is final when DONE is set.
- Undefined: no adder or register is built, and CSR 5 reads 0.

## Structure
- Shared package `nios_fprint_dma_pkg`:
  - CSR index constants.
  - CTRL/STATUS bit positions.
  - FSM state enum.
- One natural sub-module, `nios_fprint_dma_csr`: register file, W1C logic, readdata register. The FSM and datapath stay in the top level.

## Test plan
- Load, zero waits: MADDR=0x1000, SPOFF=10, LENGTH=4, memory words 0xA0..0xA3 -> scratchpad 10..13 hold 0xA0..0xA3. DONE at GO+9. With checksum built, CHECKSUM=0x286.
- Load with m_waitrequest high 3 cycles on each read -> same data, DONE at GO+21, m_read held steady throughout each stall.
- Writeback: SPOFF=4094, LENGTH=2 -> two m_write at 0x1000 and 0x1004 carrying scratchpad words 4094 and 4095. No ERR.
- Boundaries:
  - SPOFF=4095, LENGTH=2 -> ERR=DONE=1, no strobes.
  - LENGTH=0 -> DONE=1, ERR=0, no strobes.
- GO while BUSY is ignored. IRQ_EN=1 -> irq high after DONE; W1C of STATUS bit1 -> irq low the next cycle.
- Reset asserted during LD_RD stall -> m_read low immediately. After release: STATUS=0, irq=0, FSM IDLE.
